// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- memory-stage load/store unit for the five-stage RV32I core.
//
// Takes the EX/MEM pipeline register, issues loads/stores on a valid/ready
// data-memory port, aligns and sign/zero-extends load data, and presents the
// retiring instruction to MEM/WB. Upstream stages are stalled while an access
// is outstanding. Non-memory instructions and load/store exceptions retire in
// their entry cycle with no stall.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   mem_*                EX/MEM register contents (valid, pc, instr, address,
//                        store data, rd index/enable, EX result)
//   dmem_req_*           registered request channel (valid/ready, we, addr,
//                        lane-replicated wdata, byte strobes)
//   dmem_resp_*          load response (valid, aligned 32-bit word)
//   stall_o              hold EX/MEM and earlier stages
//   wb_*                 retiring instruction toward MEM/WB, with misaligned
//                        and illegal-funct3 exception flags
// -----------------------------------------------------------------------------
module mem_lsu #(
  parameter int XLEN          = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     mem_valid_i,
  input  logic [XLEN-1:0]          mem_pc_i,
  input  logic [31:0]              mem_instr_i,
  input  logic [XLEN-1:0]          mem_alu_res_i,
  input  logic [XLEN-1:0]          mem_rs2_rdata_i,
  input  logic [REG_IDX_WIDTH-1:0] mem_rd_idx_i,
  input  logic                     mem_rd_en_i,
  input  logic [XLEN-1:0]          mem_rd_wdata_i,

  output logic                     dmem_req_valid_o,
  input  logic                     dmem_req_ready_i,
  output logic                     dmem_req_we_o,
  output logic [XLEN-1:0]          dmem_req_addr_o,
  output logic [XLEN-1:0]          dmem_req_wdata_o,
  output logic [3:0]               dmem_req_wstrb_o,
  input  logic                     dmem_resp_valid_i,
  input  logic [XLEN-1:0]          dmem_resp_rdata_i,

  output logic                     stall_o,

  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_pc_o,
  output logic [31:0]              wb_instr_o,
  output logic [REG_IDX_WIDTH-1:0] wb_rd_idx_o,
  output logic                     wb_rd_en_o,
  output logic [XLEN-1:0]          wb_rd_wdata_o,
  output logic                     wb_misalign_o,
  output logic                     wb_illegal_o
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word.
  function automatic logic [XLEN-1:0] store_lanes(input logic [1:0]      size,
                                                  input logic [XLEN-1:0] rs2);
    case (size)
      2'b00:   return {4{rs2[7:0]}};
      2'b01:   return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  function automatic logic [3:0] store_strobes(input logic [1:0] size,
                                               input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Pick the addressed byte/halfword lane of the response word and extend it.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                   input logic [1:0]      lo,
                                                   input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return word;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Decode of the instruction sitting in EX/MEM
  // ---------------------------------------------------------------------------
  logic [2:0] funct3;
  logic       is_load;
  logic       is_store;
  logic       illegal;
  logic       misalign;
  logic       start;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    funct3   = mem_instr_i[14:12];
    is_load  = (mem_instr_i[6:0] == OPC_LOAD);
    is_store = (mem_instr_i[6:0] == OPC_STORE);
    illegal  = 1'b0;
    misalign = 1'b0;
    if (is_load)
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    else if (is_store)
      illegal = (funct3 > 3'b010);
    // Misalignment is only meaningful for a legal size encoding.
    if ((is_load || is_store) && !illegal)
      misalign = (funct3[1:0] == 2'b01 && mem_alu_res_i[0]) ||
                 (funct3[1:0] == 2'b10 && mem_alu_res_i[1:0] != 2'b00);
    start = mem_valid_i && (is_load || is_store) && !illegal && !misalign;
  end

  // ---------------------------------------------------------------------------
  // FSM and registered request / captured result
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]          pc_q;
  logic [31:0]              instr_q;
  logic [REG_IDX_WIDTH-1:0] rd_idx_q;
  logic                     rd_en_q;
  logic                     load_q;
  logic [XLEN-1:0]          result_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      dmem_req_valid_o <= 1'b0;
      dmem_req_we_o    <= 1'b0;
      dmem_req_addr_o  <= '0;
      dmem_req_wdata_o <= '0;
      dmem_req_wstrb_o <= 4'b0000;
      pc_q             <= '0;
      instr_q          <= '0;
      rd_idx_q         <= '0;
      rd_en_q          <= 1'b0;
      load_q           <= 1'b0;
      result_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc_q             <= mem_pc_i;
            instr_q          <= mem_instr_i;
            rd_idx_q         <= mem_rd_idx_i;
            rd_en_q          <= mem_rd_en_i;
            load_q           <= is_load;
            result_q         <= '0;
            dmem_req_valid_o <= 1'b1;
            dmem_req_we_o    <= is_store;
            dmem_req_addr_o  <= mem_alu_res_i;
            dmem_req_wdata_o <= store_lanes(funct3[1:0], mem_rs2_rdata_i);
            dmem_req_wstrb_o <= is_store ? store_strobes(funct3[1:0], mem_alu_res_i[1:0])
                                         : 4'b0000;
            state            <= REQ;
          end
        end
        REQ: begin
          // Request fields hold until the handshake completes.
          if (dmem_req_ready_i) begin
            dmem_req_valid_o <= 1'b0;
            dmem_req_we_o    <= 1'b0;
            dmem_req_wstrb_o <= 4'b0000;
            state            <= load_q ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (dmem_resp_valid_i) begin
            result_q <= load_extract(instr_q[14:12], dmem_req_addr_o[1:0],
                                     dmem_resp_rdata_i);
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back / stall outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_o       = 1'b0;
    wb_valid_o    = 1'b0;
    wb_pc_o       = '0;
    wb_instr_o    = '0;
    wb_rd_idx_o   = '0;
    wb_rd_en_o    = 1'b0;
    wb_rd_wdata_o = '0;
    wb_misalign_o = 1'b0;
    wb_illegal_o  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid_i) begin
          if (start) begin
            stall_o = 1'b1;
          end else begin
            // Non-memory op passes straight through; an exception retires
            // here too, with its flag set and the register write suppressed.
            wb_valid_o    = 1'b1;
            wb_pc_o       = mem_pc_i;
            wb_instr_o    = mem_instr_i;
            wb_rd_idx_o   = mem_rd_idx_i;
            wb_rd_wdata_o = mem_rd_wdata_i;
            wb_misalign_o = misalign;
            wb_illegal_o  = illegal;
            wb_rd_en_o    = mem_rd_en_i && !misalign && !illegal;
          end
        end
      end
      REQ, WAIT: stall_o = 1'b1;
      DONE: begin
        wb_valid_o    = 1'b1;
        wb_pc_o       = pc_q;
        wb_instr_o    = instr_q;
        wb_rd_idx_o   = rd_idx_q;
        wb_rd_en_o    = rd_en_q && load_q;
        wb_rd_wdata_o = result_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i, mem_instr_i, mem_alu_res_i, mem_rs2_rdata_i, mem_rd_wdata_i;
  logic [4:0]  mem_rd_idx_i;
  logic        mem_rd_en_i;
  logic        dmem_req_valid_o, dmem_req_ready_i, dmem_req_we_o;
  logic [31:0] dmem_req_addr_o, dmem_req_wdata_o;
  logic [3:0]  dmem_req_wstrb_o;
  logic        dmem_resp_valid_i;
  logic [31:0] dmem_resp_rdata_i;
  logic        stall_o, wb_valid_o, wb_rd_en_o, wb_misalign_o, wb_illegal_o;
  logic [31:0] wb_pc_o, wb_instr_o, wb_rd_wdata_o;
  logic [4:0]  wb_rd_idx_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk               (clk),
    .rst               (rst),
    .mem_valid_i       (mem_valid_i),
    .mem_pc_i          (mem_pc_i),
    .mem_instr_i       (mem_instr_i),
    .mem_alu_res_i     (mem_alu_res_i),
    .mem_rs2_rdata_i   (mem_rs2_rdata_i),
    .mem_rd_idx_i      (mem_rd_idx_i),
    .mem_rd_en_i       (mem_rd_en_i),
    .mem_rd_wdata_i    (mem_rd_wdata_i),
    .dmem_req_valid_o  (dmem_req_valid_o),
    .dmem_req_ready_i  (dmem_req_ready_i),
    .dmem_req_we_o     (dmem_req_we_o),
    .dmem_req_addr_o   (dmem_req_addr_o),
    .dmem_req_wdata_o  (dmem_req_wdata_o),
    .dmem_req_wstrb_o  (dmem_req_wstrb_o),
    .dmem_resp_valid_i (dmem_resp_valid_i),
    .dmem_resp_rdata_i (dmem_resp_rdata_i),
    .stall_o           (stall_o),
    .wb_valid_o        (wb_valid_o),
    .wb_pc_o           (wb_pc_o),
    .wb_instr_o        (wb_instr_o),
    .wb_rd_idx_o       (wb_rd_idx_o),
    .wb_rd_en_o        (wb_rd_en_o),
    .wb_rd_wdata_o     (wb_rd_wdata_o),
    .wb_misalign_o     (wb_misalign_o),
    .wb_illegal_o      (wb_illegal_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_valid_i       = 1'b0;
    mem_pc_i          = '0;
    mem_instr_i       = '0;
    mem_alu_res_i     = '0;
    mem_rs2_rdata_i   = '0;
    mem_rd_idx_i      = '0;
    mem_rd_en_i       = 1'b0;
    mem_rd_wdata_i    = '0;
    dmem_req_ready_i  = 1'b0;
    dmem_resp_valid_i = 1'b0;
    dmem_resp_rdata_i = '0;
  endtask

  // Runs one instruction through the unit, acting as the data memory, and
  // compares everything against expectations derived from the ISA rules.
  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rd_en,
                        input logic [31:0] ex_wdata, input logic [31:0] word,
                        input int rdy_dly, input int resp_dly, input bit stray);
    logic [31:0] pc, instr, exp_wd, exp_res, v;
    logic [3:0]  exp_strb;
    bit ld, st, ill, mis, legal;
    int lo, exp_stalls, stalls, cyc, rdy_cnt, resp_cnt;
    bit got_req, unstable, accepted, responded, done;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_strb;
    logic        r_we;
    logic [31:0] o_wd, o_pc, o_instr;
    logic [4:0]  o_idx;
    logic        o_en, o_mis, o_ill;

    // ---- reference model ----
    ld    = (opc == OPC_LOAD);
    st    = (opc == OPC_STORE);
    ill   = ld ? (f3 == 3 || f3 == 6 || f3 == 7) : (st ? (f3 > 2) : 1'b0);
    mis   = (ld || st) && !ill &&
            ((f3[1:0] == 1 && addr % 2 != 0) || (f3[1:0] == 2 && addr % 4 != 0));
    legal = (ld || st) && !ill && !mis;
    lo    = int'(addr % 4);
    case (f3[1:0])
      2'd0:    begin exp_wd = (rs2 & 32'hFF) * 32'h0101_0101;   exp_strb = 4'(1 << lo); end
      2'd1:    begin exp_wd = (rs2 & 32'hFFFF) * 32'h0001_0001; exp_strb = 4'(3 << lo); end
      default: begin exp_wd = rs2;                              exp_strb = 4'hF;        end
    endcase
    case (f3)
      3'd0: begin v = (word >> (8 * lo)) & 255;          exp_res = (v >= 128)   ? v - 256   : v; end
      3'd1: begin v = (word >> (16 * (lo / 2))) & 65535; exp_res = (v >= 32768) ? v - 65536 : v; end
      3'd4: exp_res = (word >> (8 * lo)) & 255;
      3'd5: exp_res = (word >> (16 * (lo / 2))) & 65535;
      default: exp_res = word;
    endcase
    exp_stalls = !legal ? 0 : (ld ? 3 + rdy_dly + resp_dly : 2 + rdy_dly);

    // ---- drive the instruction ----
    pc          = $urandom & 32'hFFFF_FFFC;
    instr       = $urandom;
    instr[6:0]  = opc;
    instr[14:12] = f3;
    mem_valid_i     = 1'b1;
    mem_pc_i        = pc;
    mem_instr_i     = instr;
    mem_alu_res_i   = addr;
    mem_rs2_rdata_i = rs2;
    mem_rd_idx_i    = rd;
    mem_rd_en_i     = rd_en;
    mem_rd_wdata_i  = ex_wdata;

    stalls = 0; cyc = 0; rdy_cnt = 0; resp_cnt = 0;
    got_req = 0; unstable = 0; accepted = 0; responded = 0; done = 0;
    r_addr = '0; r_wdata = '0; r_strb = '0; r_we = 1'b0;
    o_wd = '0; o_pc = '0; o_instr = '0; o_idx = '0; o_en = 1'b0; o_mis = 1'b0; o_ill = 1'b0;

    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      dmem_resp_valid_i = 1'b0;
      dmem_resp_rdata_i = $urandom;
      // Junk responses only where the unit is not waiting for load data.
      if (stray && (!ld || !accepted)) dmem_resp_valid_i = 1'b1;
      if (ld && accepted && !responded) begin
        if (resp_cnt >= resp_dly) begin
          dmem_resp_valid_i = 1'b1;
          dmem_resp_rdata_i = word;
          responded = 1;
        end
        resp_cnt++;
      end
      if (dmem_req_valid_o) begin
        if (!got_req) begin
          r_addr = dmem_req_addr_o; r_wdata = dmem_req_wdata_o;
          r_strb = dmem_req_wstrb_o; r_we = dmem_req_we_o;
        end else if (r_addr !== dmem_req_addr_o || r_wdata !== dmem_req_wdata_o ||
                     r_strb !== dmem_req_wstrb_o || r_we !== dmem_req_we_o) begin
          unstable = 1;
        end
        got_req = 1;
        dmem_req_ready_i = (rdy_cnt >= rdy_dly);
        if (dmem_req_ready_i) accepted = 1;
        rdy_cnt++;
      end else begin
        dmem_req_ready_i = 1'($urandom_range(0, 1));
      end
      if (stall_o) stalls++;
      if (wb_valid_o) begin
        done = 1;
        o_wd = wb_rd_wdata_o; o_pc = wb_pc_o; o_instr = wb_instr_o; o_idx = wb_rd_idx_o;
        o_en = wb_rd_en_o; o_mis = wb_misalign_o; o_ill = wb_illegal_o;
      end
    end

    check("op_completed", 32'(done), 32'd1);
    if (done) begin
      check("wb_pc", o_pc, pc);
      check("wb_instr", o_instr, instr);
      check("wb_rd_idx", 32'(o_idx), 32'(rd));
      check("wb_misalign", 32'(o_mis), 32'(mis));
      check("wb_illegal", 32'(o_ill), 32'(ill));
      check("stall_cycles", 32'(stalls), 32'(exp_stalls));
      check("req_issued", 32'(got_req), 32'(legal));
      if (legal) begin
        check("req_addr", r_addr, addr);
        check("req_we", 32'(r_we), 32'(st));
        check("req_wstrb", 32'(r_strb), st ? 32'(exp_strb) : 32'd0);
        if (st) check("req_wdata", r_wdata, exp_wd);
        check("req_stable", 32'(unstable), 32'd0);
        check("wb_rd_en", 32'(o_en), 32'(ld && rd_en));
        if (ld) check("load_data", o_wd, exp_res);
      end else if (ld || st) begin
        check("exc_rd_en", 32'(o_en), 32'd0);
      end else begin
        check("pass_rd_en", 32'(o_en), 32'(rd_en));
        check("pass_wdata", o_wd, ex_wdata);
      end
    end

    @(posedge clk);
    #1;
    check("no_req_after", 32'(dmem_req_valid_o), 32'd0);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req_valid", 32'(dmem_req_valid_o), 32'd0);
    check("rst_req_we", 32'(dmem_req_we_o), 32'd0);
    check("rst_req_wstrb", 32'(dmem_req_wstrb_o), 32'd0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_wb_flags", {30'd0, wb_misalign_o, wb_illegal_o}, 32'd0);
    check("rst_wb_wdata", wb_rd_wdata_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases.
    run_op(OPC_OP,    3'd0, 32'h0,    32'h0,         5'd5,  1'b1, 32'h1234, 32'h0,         0, 0, 0);
    run_op(OPC_LOAD,  3'd0, 32'h1003, 32'h0,         5'd7,  1'b1, 32'h0,    32'h80FF_0000, 0, 0, 0);
    run_op(OPC_LOAD,  3'd4, 32'h1003, 32'h0,         5'd7,  1'b1, 32'h0,    32'h80FF_0000, 0, 0, 0);
    run_op(OPC_STORE, 3'd1, 32'h2002, 32'hDEAD_BEEF, 5'd9,  1'b1, 32'h0,    32'h0,         0, 0, 0);
    run_op(OPC_LOAD,  3'd2, 32'h3001, 32'h0,         5'd3,  1'b1, 32'h0,    32'h0,         0, 0, 0);
    run_op(OPC_LOAD,  3'd3, 32'h3000, 32'h0,         5'd3,  1'b1, 32'h0,    32'h0,         0, 0, 0);
    run_op(OPC_LOAD,  3'd2, 32'h4000, 32'h0,         5'd11, 1'b1, 32'h0,    32'h1234_5678, 4, 0, 0);
    run_op(OPC_STORE, 3'd2, 32'h0102, 32'h1111_2222, 5'd0,  1'b0, 32'h0,    32'h0,         0, 0, 0);
    run_op(OPC_LOAD,  3'd5, 32'h0042, 32'h0,         5'd12, 1'b1, 32'h0,    32'hF00D_8001, 1, 2, 1);

    // Reset while waiting for load data; a late response must be ignored.
    mem_valid_i   = 1'b1;
    mem_instr_i   = {17'd0, 3'd0, 5'd4, OPC_LOAD};
    mem_alu_res_i = 32'h10;
    mem_rd_idx_i  = 5'd4;
    mem_rd_en_i   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_in_req", 32'(dmem_req_valid_o), 32'd1);
    dmem_req_ready_i = 1'b1;
    @(negedge clk);
    dmem_req_ready_i = 1'b0;
    rst = 1'b1;
    mem_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dmem_resp_valid_i = 1'b1;
    dmem_resp_rdata_i = 32'hA5A5_A5A5;
    @(negedge clk);
    check("rst_mid_stall", 32'(stall_o), 32'd0);
    check("rst_mid_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_mid_req_valid", 32'(dmem_req_valid_o), 32'd0);
    @(posedge clk);
    #1;
    dmem_resp_valid_i = 1'b0;
    @(negedge clk);
    check("rst_mid_late_resp", 32'(wb_valid_o), 32'd0);
    check("rst_mid_stall2", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          k;
      k = $urandom_range(0, 9);
      opc = (k < 5) ? OPC_LOAD : (k < 8) ? OPC_STORE : 7'($urandom_range(0, 127));
      if (opc == OPC_LOAD && k >= 8) opc = OPC_OP;
      if (opc == OPC_STORE && k >= 8) opc = OPC_OP;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (opc == OPC_STORE) f3 = 3'($urandom_range(0, 2));
        else begin
          k = $urandom_range(0, 4);
          f3 = (k == 3) ? 3'd4 : (k == 4) ? 3'd5 : 3'(k);
        end
      end
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) addr[0] = 1'b0;
        if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
      end
      run_op(opc, f3, addr, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
